dmem_bus_bridge: RTL and testbench

- Sits directly downstream of the core's memory stage and converts its single-cycle data-memory request into a held request/acknowledge bus transaction with variable latency.
- Inputs from the core: memreadM, memwriteM, aluoutM, writedataM, selectM. Returns readdataM.
- Drives a stall into the hazard unit while a transaction is outstanding.
- A watchdog counter aborts transactions that are never acknowledged.

---
 rtl/dmem_bus_bridge.sv | 139 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's single-cycle M-stage data access onto a held req/ack bus
// with variable latency, stalling the pipeline and aborting stuck transactions.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [3:0]  selectM,
  output logic [31:0] readdataM,
  input  logic        cpu_stall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic [1:0]  bus_size,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err_o
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    sIdle,
    sReq,
    sDone
  } stateT;

  stateT         state;
  stateT         stateNext;
  logic [CW-1:0] cnt;
  logic          flushed;
  logic          go;
  logic          issue;
  logic          finish;
  logic          abort;
  logic [1:0]    sizeSel;

  always_comb begin
    case (selectM)
      4'b1111:                            sizeSel = 2'd2;
      4'b0011, 4'b1100:                   sizeSel = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sizeSel = 2'd0;
      default:                            sizeSel = 2'd2;
    endcase
  end

  always_comb begin
    go        = (memreadM | memwriteM) & (selectM != '0) & ~flush_i;
    stateNext = state;
    stall_o   = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      sIdle: begin
        stall_o = go;
        if (go) begin
          stateNext = sReq;
          issue     = 1'b1;
        end
      end
      sReq: begin
        stall_o = 1'b1;
        if (bus_ack) begin
          finish = 1'b1;
        end else if (cnt == TMAX) begin
          finish = 1'b1;
          abort  = 1'b1;
        end
        // A flush seen at any point of the transaction, including the
        // completing cycle, kills the instruction: skip DONE entirely.
        if (finish) begin
          stateNext = (flushed | flush_i) ? sIdle : sDone;
        end
      end
      sDone: begin
        if (!cpu_stall_i) begin
          stateNext = sIdle;
        end
      end
      default: stateNext = sIdle;
    endcase
    if (!rst) begin
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= sIdle;
      cnt       <= '0;
      flushed   <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      bus_size  <= '0;
      bus_err_o <= 1'b0;
      readdataM <= '0;
    end else begin
      state     <= stateNext;
      bus_err_o <= abort;
      if (issue) begin
        bus_req   <= 1'b1;
        bus_wr    <= memwriteM;
        bus_addr  <= aluoutM;
        bus_wdata <= writedataM;
        bus_wstrb <= memwriteM ? selectM : '0;
        bus_size  <= sizeSel;
        cnt       <= '0;
        flushed   <= 1'b0;
      end else if (state == sReq) begin
        if (flush_i) begin
          flushed <= 1'b1;
        end
        if (finish) begin
          bus_req <= 1'b0;
          if (!bus_wr && !(flushed | flush_i)) begin
            readdataM <= abort ? ERR_RDATA : bus_rdata;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_dmem_bus_bridge;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [3:0]  selectM;
  logic [31:0] readdataM;
  logic        cpu_stall_i;
  logic        flush_i;
  logic        stall_o;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [1:0]  bus_size;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err_o;

  dmem_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .aluoutM(aluoutM),
    .writedataM(writedataM), .selectM(selectM), .readdataM(readdataM),
    .cpu_stall_i(cpu_stall_i), .flush_i(flush_i), .stall_o(stall_o),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_size(bus_size),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // bus responder: acks ackDelay cycles after bus_req rises (-1 = never)
  int          ackDelay = 3;
  logic [31:0] rdataVal = 32'hDEAD_BEEF;
  bit          randMode = 0;
  bit          prevReqR = 0;
  int          age      = 0;

  initial begin
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_req) begin
        if (!prevReqR) begin
          age = 0;
          if (randMode) ackDelay = $urandom_range(0, 10);
        end else begin
          age++;
        end
        bus_ack = (age == ackDelay);
      end else begin
        bus_ack = randMode && ($urandom_range(0, 5) == 0);
      end
      prevReqR  = bus_req;
      bus_rdata = randMode ? $urandom : rdataVal;
    end
  end

  // observation counters used by directed scenarios
  int          stallCycles, reqHigh, reqRises, errPulses;
  bit          monPrevReq = 0;
  logic        lastWr;
  logic [31:0] lastAddr, lastWdata;
  logic [3:0]  lastWstrb;
  logic [1:0]  lastSize;

  task automatic clearMon();
    stallCycles = 0; reqHigh = 0; reqRises = 0; errPulses = 0;
  endtask

  // reference model: one outstanding transaction, then an optional hold phase
  bit          mBusy = 0, mHold = 0, mFl = 0;
  int          mAge = 0;
  logic        eReq = 0, eWr = 0, eErr = 0;
  logic [31:0] eAddr = '0, eWdata = '0, eRdata = '0;
  logic [3:0]  eWstrb = '0;
  logic [1:0]  eSize = '0;

  function automatic logic [1:0] sizeRule(input logic [3:0] s);
    if (s == 4'b0011 || s == 4'b1100) return 2'd1;
    if ($countones(s) == 1) return 2'd0;
    return 2'd2;
  endfunction

  initial begin
    bit   goNow, fl;
    logic expStall;
    @(posedge clk);
    forever begin
      @(negedge clk);
      goNow    = (memreadM || memwriteM) && (selectM != 4'b0) && !flush_i;
      expStall = !rst ? 1'b0 : mBusy ? 1'b1 : mHold ? 1'b0 : goNow;
      check("stall_o", 32'(stall_o), 32'(expStall));
      check("bus_req", 32'(bus_req), 32'(eReq));
      check("bus_err_o", 32'(bus_err_o), 32'(eErr));
      check("readdataM", readdataM, eRdata);
      if (eReq) begin
        check("bus_wr", 32'(bus_wr), 32'(eWr));
        check("bus_addr", bus_addr, eAddr);
        check("bus_wstrb", 32'(bus_wstrb), 32'(eWstrb));
        check("bus_size", 32'(bus_size), 32'(eSize));
        if (eWr) check("bus_wdata", bus_wdata, eWdata);
      end

      if (stall_o) stallCycles++;
      if (bus_req) begin
        reqHigh++;
        if (!monPrevReq) reqRises++;
        lastWr = bus_wr; lastAddr = bus_addr; lastWdata = bus_wdata;
        lastWstrb = bus_wstrb; lastSize = bus_size;
      end
      monPrevReq = bus_req;
      if (bus_err_o) errPulses++;

      if (!rst) begin
        mBusy = 0; mHold = 0; eReq = 0; eWr = 0; eErr = 0;
        eAddr = '0; eWdata = '0; eWstrb = '0; eSize = '0; eRdata = '0;
      end else begin
        eErr = 0;
        if (mBusy) begin
          fl = mFl || flush_i;
          if (bus_ack || mAge == TO) begin
            eReq  = 0;
            mBusy = 0;
            eErr  = !bus_ack;
            if (!fl && !eWr) eRdata = bus_ack ? bus_rdata : 32'h0;
            mHold = !fl;
          end else begin
            mAge++;
            mFl = fl;
          end
        end else if (mHold) begin
          if (!cpu_stall_i) mHold = 0;
        end else if (goNow) begin
          mBusy  = 1; mAge = 0; mFl = 0;
          eReq   = 1;
          eWr    = memwriteM;
          eAddr  = aluoutM;
          eWdata = writedataM;
          eWstrb = memwriteM ? selectM : 4'b0;
          eSize  = sizeRule(selectM);
        end
      end
    end
  end

  logic [31:0] capRdata;

  task automatic idleInputs();
    memreadM = 0; memwriteM = 0; selectM = '0; aluoutM = '0; writedataM = '0;
    flush_i = 0; cpu_stall_i = 0;
  endtask

  task automatic runTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input int delay, input int hold);
    int n;
    bit fin;
    clearMon();
    ackDelay    = delay;
    memwriteM   = wr;
    memreadM    = !wr;
    aluoutM     = addr;
    writedataM  = wdata;
    selectM     = sel;
    cpu_stall_i = (hold > 0);
    n = 0; fin = 0;
    while (!fin && n < 60) begin
      @(negedge clk); n++;
      if (!stall_o) fin = 1;
    end
    if (!fin) begin
      nChecks++; nFail++;
      $display("FAIL txn_wait: stall_o still %b after %0d cycles, required 0", stall_o, n);
    end
    capRdata = readdataM;
    if (hold > 0) begin
      repeat (hold - 1) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("done_hold_rdata", readdataM, capRdata);
        check("done_hold_stall", 32'(stall_o), 32'd0);
      end
      @(posedge clk); #1;
      cpu_stall_i = 0;
    end
    @(posedge clk); #1;
    idleInputs();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 0;
    idleInputs();
    memreadM = 1; selectM = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall_forced", 32'(stall_o), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_readdata", readdataM, 32'd0);
    @(posedge clk); #1;
    rst = 1;
    idleInputs();
    @(posedge clk); #1;

    // load word, ack 3 cycles after req
    rdataVal = 32'hDEAD_BEEF;
    runTxn(1'b0, 32'h0000_1004, 32'h0, 4'hF, 3, 0);
    check("lw_rdata", capRdata, 32'hDEAD_BEEF);
    check("lw_stall_cycles", 32'(stallCycles), 32'd5);
    check("lw_req_rises", 32'(reqRises), 32'd1);
    check("lw_req_cycles", 32'(reqHigh), 32'd4);
    check("lw_size", 32'(lastSize), 32'd2);
    check("lw_wstrb", 32'(lastWstrb), 32'd0);
    check("lw_addr", lastAddr, 32'h0000_1004);

    // store byte, same-cycle ack
    runTxn(1'b1, 32'h0000_2002, 32'h0012_0000, 4'b0100, 0, 0);
    check("sb_stall_cycles", 32'(stallCycles), 32'd2);
    check("sb_wr", 32'(lastWr), 32'd1);
    check("sb_wstrb", 32'(lastWstrb), 32'h4);
    check("sb_size", 32'(lastSize), 32'd0);
    check("sb_wdata", lastWdata, 32'h0012_0000);
    check("sb_rdata_kept", readdataM, 32'hDEAD_BEEF);

    // halfword load held in DONE by cpu_stall_i
    rdataVal = 32'hCAFE_F00D;
    runTxn(1'b0, 32'h0000_3000, 32'h0, 4'b0011, 1, 4);
    check("hold_rdata", capRdata, 32'hCAFE_F00D);
    check("hold_stall_cycles", 32'(stallCycles), 32'd3);
    check("hold_req_rises", 32'(reqRises), 32'd1);
    check("hold_size", 32'(lastSize), 32'd1);

    // timeout: no ack ever
    runTxn(1'b0, 32'h0000_4000, 32'h0, 4'hF, -1, 0);
    check("to_rdata", capRdata, 32'h0);
    check("to_stall_cycles", 32'(stallCycles), 32'd10);
    check("to_req_cycles", 32'(reqHigh), 32'd9);
    check("to_err_pulses", 32'(errPulses), 32'd1);

    // store with no lanes is a no-op
    clearMon();
    memwriteM = 1; selectM = 4'b0; aluoutM = 32'h0000_5000;
    repeat (3) @(posedge clk);
    #1;
    idleInputs();
    check("nolane_stall", 32'(stallCycles), 32'd0);
    check("nolane_req", 32'(reqRises), 32'd0);

    // flush in IDLE blocks the request
    clearMon();
    memreadM = 1; selectM = 4'hF; flush_i = 1;
    repeat (3) @(posedge clk);
    #1;
    idleInputs();
    check("flush_idle_stall", 32'(stallCycles), 32'd0);
    check("flush_idle_req", 32'(reqRises), 32'd0);

    // flush during REQ: finish on bus, keep readdataM, straight to IDLE
    @(posedge clk); #1;
    clearMon();
    ackDelay = 3; rdataVal = 32'h1111_2222;
    memreadM = 1; aluoutM = 32'h0000_5000; selectM = 4'hF; cpu_stall_i = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_i = 1;
    @(posedge clk); #1;
    flush_i = 0; memreadM = 0; selectM = '0;
    @(posedge clk); #1;
    memreadM = 1; aluoutM = 32'h0000_6000; selectM = 4'hF;
    @(negedge clk);
    check("flush_req_stall_cycles", 32'(stallCycles), 32'd5);
    @(posedge clk); #1;
    cpu_stall_i = 0;
    @(negedge clk);
    check("flush_req_to_idle", 32'(stall_o), 32'd1);
    check("flush_req_rdata_kept", readdataM, 32'h0);
    check("flush_req_rises", 32'(reqRises), 32'd1);
    n = 0;
    while (stall_o && n < 60) begin
      @(negedge clk); n++;
    end
    if (stall_o) begin
      nChecks++; nFail++;
      $display("FAIL flush_next_wait: stall_o still 1 after %0d cycles, required 0", n);
    end
    @(posedge clk); #1;
    idleInputs();
    check("flush_next_rdata", readdataM, 32'h1111_2222);
    @(posedge clk); #1;

    // reset while in REQ
    clearMon();
    ackDelay = -1;
    memreadM = 1; aluoutM = 32'h0000_7000; selectM = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("rstmid_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_req", 32'(bus_req), 32'd0);
    check("rstmid_rdata", readdataM, 32'h0);
    check("rstmid_addr", bus_addr, 32'h0);
    check("rstmid_size", 32'(bus_size), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    idleInputs();
    @(posedge clk); #1;
    rdataVal = 32'hAAAA_5555;
    runTxn(1'b0, 32'h0000_8003, 32'h0, 4'b1000, 2, 0);
    check("post_rst_rdata", capRdata, 32'hAAAA_5555);
    check("post_rst_stall_cycles", 32'(stallCycles), 32'd4);
    check("post_rst_size", 32'(lastSize), 32'd0);

    // randomized traffic, checked by the model every cycle
    randMode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 9) < 4) begin
        memreadM   = 1'($urandom_range(0, 1));
        memwriteM  = ($urandom_range(0, 3) == 0);
        aluoutM    = $urandom;
        writedataM = $urandom;
        case ($urandom_range(0, 5))
          0:       selectM = 4'hF;
          1:       selectM = 4'h3;
          2:       selectM = 4'hC;
          3:       selectM = 4'(1 << $urandom_range(0, 3));
          4:       selectM = 4'h0;
          default: selectM = 4'($urandom);
        endcase
      end
      cpu_stall_i = ($urandom_range(0, 3) == 0);
      flush_i     = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    rst = 1;
    idleInputs();
    randMode = 0;
    repeat (20) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
